// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register.
package univ_shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

endpackage

// File: rtl/usr_cell.sv
// One bit of the universal shift register: 4:1 next-state mux plus a flop.
module usr_cell
    import univ_shift_reg_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  logic  clr,
    input  mode_t mode,
    input  logic  d,
    input  logic  shr_in,
    input  logic  shl_in,
    output logic  q
);

    logic q_d;

    always_comb begin
        q_d = q;
        if (clr) begin
            q_d = 1'b0;
        end else begin
            case (mode)
                MODE_HOLD: q_d = q;
                MODE_SHR:  q_d = shr_in;
                MODE_SHL:  q_d = shl_in;
                MODE_LOAD: q_d = d;
                // Unknown mode poisons the bit in 4-state simulation.
                default:   q_d = 1'bx;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (en) begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with saturating shift counter.
// Define UNIV_SHIFT_REG_ROTATE_EN to turn serial shifts into rotations.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(WIDTH);

    mode_t            mode_e;
    logic             msb_in;
    logic             lsb_in;
    logic [WIDTH-1:0] shr_src;
    logic [WIDTH-1:0] shl_src;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    assign mode_e = mode_t'(mode);

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    logic unused_sin;
    assign unused_sin = sin_msb ^ sin_lsb;
    assign msb_in     = q[0];
    assign lsb_in     = q[WIDTH-1];
`else
    assign msb_in = sin_msb;
    assign lsb_in = sin_lsb;
`endif

    // Bit i takes q[i+1] on shift right and q[i-1] on shift left.
    assign shr_src = {msb_in, q[WIDTH-1:1]};
    assign shl_src = {q[WIDTH-2:0], lsb_in};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        usr_cell u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .clr    (clr),
            .mode   (mode_e),
            .d      (d[i]),
            .shr_in (shr_src[i]),
            .shl_in (shl_src[i]),
            .q      (q[i])
        );
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else begin
            case (mode_e)
                MODE_SHR, MODE_SHL: begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                MODE_LOAD: cnt_d = '0;
                default:   cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

    assign shift_cnt = cnt_q;
    assign done      = (cnt_q == CntMax);

endmodule
